traffic_light_fsm: RTL and testbench

//  Single-road traffic-light sequencer: cycles RED -> GREEN -> YELLOW -> RED indefinitely.

---
 rtl/traffic_light_pkg.sv | 24 ++
 rtl/traffic_light_fsm_phase_timer.sv | 28 ++
 rtl/traffic_light_fsm.sv | 73 +++++++
 tb/tb_traffic_light_fsm.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared types and default timing for the single-road traffic-light sequencer.
package traffic_light_pkg;

  // Light code doubles as the FSM state encoding; 2'b11 is never a legal phase.
  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } light_t;

  localparam int DEF_RED_CYCLES    = 4;
  localparam int DEF_GREEN_CYCLES  = 4;
  localparam int DEF_YELLOW_CYCLES = 2;

  // Timer width able to hold the largest (DURATION-1); never narrower than 1 bit.
  function automatic int cnt_width(input int r, input int g, input int y);
    int m;
    m = r;
    if (g > m) m = g;
    if (y > m) m = y;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/traffic_light_fsm_phase_timer.sv
// Loadable phase down-counter; expired flags the last cycle of the current phase.
module phase_timer #(
  parameter int              CNT_W   = 2,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // Reload on phase change, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/traffic_light_fsm.sv
// Traffic-light sequencer: RED -> GREEN -> YELLOW -> RED, each phase held for a
// fixed number of cycles. The light output is the state register itself.
module traffic_light_fsm
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = DEF_RED_CYCLES,
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] light
);

  localparam int CNT_W = cnt_width(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES);
  localparam logic [CNT_W-1:0] RED_RELOAD = CNT_W'(RED_CYCLES - 1);

  light_t           state;
  light_t           next_state;
  logic             illegal;
  logic             expired;
  logic             load;
  logic [CNT_W-1:0] load_val;

  // Timer reload value for the phase about to be entered.
  function automatic logic [CNT_W-1:0] phase_len_m1(input light_t s);
    case (s)
      GREEN:   return CNT_W'(GREEN_CYCLES - 1);
      YELLOW:  return CNT_W'(YELLOW_CYCLES - 1);
      default: return RED_RELOAD;
    endcase
  endfunction

  // Next phase; an illegal code recovers to a fresh RED on the very next edge.
  always_comb begin
    next_state = RED;
    illegal    = 1'b0;
    case (state)
      RED:     next_state = GREEN;
      GREEN:   next_state = YELLOW;
      YELLOW:  next_state = RED;
      default: begin
        next_state = RED;
        illegal    = 1'b1;
      end
    endcase
    load     = expired | illegal;
    load_val = phase_len_m1(next_state);
  end

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (RED_RELOAD)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  // State register: advances only when the timer reloads; reset forces RED at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RED;
    end else if (load) begin
      state <= next_state;
    end
  end

  assign light = state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: three parameterisations against a lap-position model.
module tb_traffic_light_fsm;
  import traffic_light_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] light_def, light_min, light_big;

  int checks = 0;
  int errors = 0;

  bit chk_en = 1'b0;
  bit inj    = 1'b0;

  int t_def = 0, t_min = 0, t_big = 0;

  always #5 clk = ~clk;

  traffic_light_fsm dut_def (.clk(clk), .reset(reset), .light(light_def));
  traffic_light_fsm #(.RED_CYCLES(1), .GREEN_CYCLES(1), .YELLOW_CYCLES(1))
    dut_min (.clk(clk), .reset(reset), .light(light_min));
  traffic_light_fsm #(.RED_CYCLES(7), .GREEN_CYCLES(3), .YELLOW_CYCLES(5))
    dut_big (.clk(clk), .reset(reset), .light(light_big));

  // Expected light from position within the lap.
  function automatic logic [1:0] exp_light(input int t, input int r, input int g);
    if (t < r) return 2'b00;
    if (t < r + g) return 2'b01;
    return 2'b10;
  endfunction

  task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Lap-position models; reset or an injected illegal state restarts the lap.
  always @(posedge clk or negedge reset) begin
    if (!reset) t_def <= 0;
    else if (inj) t_def <= 0;
    else t_def <= (t_def + 1) % 10;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) t_min <= 0;
    else t_min <= (t_min + 1) % 3;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) t_big <= 0;
    else t_big <= (t_big + 1) % 15;
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check2("model_def", light_def, exp_light(t_def, 4, 4));
      check2("model_min", light_min, exp_light(t_min, 1, 1));
      check2("model_big", light_big, exp_light(t_big, 7, 3));
    end
  end

  logic [1:0] lit_def [16] = '{0,0,0,0,1,1,1,1,2,2,0,0,0,0,1,1};
  logic [1:0] lit_min [16] = '{0,1,2,0,1,2,0,1,2,0,1,2,0,1,2,0};
  logic [1:0] lit_big [16] = '{0,0,0,0,0,0,0,1,1,1,2,2,2,2,2,0};
  logic [1:0] seq_def [16];
  logic [1:0] seq_min [16];
  logic [1:0] seq_big [16];

  initial begin
    int n;
    int run;
    chk_en = 1'b1;
    reset  = 1'b0;
    repeat (2) @(negedge clk);
    check2("reset_def", light_def, 2'b00);
    check2("reset_min", light_min, 2'b00);
    check2("reset_big", light_big, 2'b00);

    // Release on a falling edge; the next rising edge is cycle 1 of RED.
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      seq_def[i] = light_def;
      seq_min[i] = light_min;
      seq_big[i] = light_big;
      @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      check2($sformatf("seq_def[%0d]", i), seq_def[i], lit_def[i]);
      check2($sformatf("seq_min[%0d]", i), seq_min[i], lit_min[i]);
      check2($sformatf("seq_big[%0d]", i), seq_big[i], lit_big[i]);
    end
    repeat (20) @(negedge clk);

    // Asynchronous reset in the middle of GREEN.
    n = 0;
    while (light_def != 2'b01 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_int("wait_green", (n < 20) ? 1 : 0, 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check2("async_rst_def", light_def, 2'b00);
    check2("async_rst_big", light_big, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    run = 0;
    for (int i = 0; i < 12; i++) begin
      if (light_def != 2'b00) break;
      run++;
      @(negedge clk);
    end
    check_int("red_len_after_rst", run, 4);
    repeat (3) @(negedge clk);

    // Illegal state injection during a non-RED phase.
    n = 0;
    while (light_def == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_int("wait_not_red", (n < 20) ? 1 : 0, 1);
    #1;
    inj = 1'b1;
    force dut_def.state = light_t'(2'b11);
    #1;
    check2("forced_code", light_def, 2'b11);
    release dut_def.state;
    @(posedge clk);
    #1;
    inj = 1'b0;
    check2("illegal_recover", light_def, 2'b00);
    @(negedge clk);
    run = 0;
    for (int i = 0; i < 12; i++) begin
      if (light_def != 2'b00) break;
      run++;
      @(negedge clk);
    end
    check_int("red_len_after_illegal", run, 4);
    repeat (12) @(negedge clk);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
